// File: rtl/bpred_pkg.sv
// Shared types and helpers for the tagged BTB / bimodal predictor.
// Field widths in entry_t are upper bounds; the top packs only the configured bits into RAM.
package bpred_pkg;

  localparam int TAG_MAX = 28;
  localparam int CTR_MAX = 4;

  typedef enum logic {
    ST_INIT  = 1'b0,
    ST_READY = 1'b1
  } state_e;

  typedef struct packed {
    logic               valid;
    logic [TAG_MAX-1:0] tag;
    logic [29:0]        target;
    logic [CTR_MAX-1:0] ctr;
  } entry_t;

  // Weakly not-taken: the value just below the taken threshold.
  function automatic logic [CTR_MAX-1:0] ctr_init(input int ctr_bits);
    return CTR_MAX'((32'd1 << (ctr_bits - 1)) - 32'd1);
  endfunction

  function automatic logic [CTR_MAX-1:0] ctr_next(input logic [CTR_MAX-1:0] ctr,
                                                  input logic dir, input int ctr_bits);
    logic [CTR_MAX-1:0] top;
    top = CTR_MAX'((32'd1 << ctr_bits) - 32'd1);
    if (dir) return (ctr == top) ? ctr : ctr + CTR_MAX'(1);
    return (ctr == '0) ? ctr : ctr - CTR_MAX'(1);
  endfunction

  function automatic logic [31:0] pc_index(input logic [31:0] pc, input int idx_bits);
    return (pc >> 2) & ((32'd1 << idx_bits) - 32'd1);
  endfunction

  function automatic logic [31:0] pc_tag(input logic [31:0] pc, input int idx_bits,
                                         input int tag_bits);
    return (pc >> (idx_bits + 2)) & ((32'd1 << tag_bits) - 32'd1);
  endfunction

endpackage

// File: rtl/bpred_ram.sv
// Simple dual-port synchronous RAM: one write port, one registered read port.
// A same-address read and write returns the old contents.
module bpred_ram #(
  parameter int DEPTH = 2048,
  parameter int WIDTH = 41
) (
  input  logic                     clk,
  input  logic                     we_i,
  input  logic [$clog2(DEPTH)-1:0] waddr_i,
  input  logic [WIDTH-1:0]         wdata_i,
  input  logic [$clog2(DEPTH)-1:0] raddr_i,
  output logic [WIDTH-1:0]         rdata_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] rdata_q;

  // NOTE: the array has no reset so it maps onto RAM macros; non-blocking writes give read-old-data.
  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
    rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/bpred_btb_tagged.sv
// Tagged direct-mapped BTB with saturating-counter direction prediction and hardware table init.
// Optional build macro BPRED_DEBUG_CNT_EN adds lookup/update/miss/hit counters on debug_data.
module bpred_btb_tagged
  import bpred_pkg::*;
#(
  parameter int ENTRIES   = 2048,
  parameter int TAG_BITS  = 8,
  parameter int CTR_BITS  = 2,
  parameter int META_BITS = 1 + $clog2(ENTRIES) + CTR_BITS
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 stall,
  input  logic                 lu_valid,
  input  logic [31:0]          lu_pc,
  output logic                 lu_ready,
  output logic                 p_valid,
  output logic                 p_hit,
  output logic                 p_dir,
  output logic [31:0]          p_target,
  output logic [META_BITS-1:0] p_meta,
  input  logic                 up_valid,
  input  logic [31:0]          up_pc,
  input  logic                 up_dir,
  input  logic [31:0]          up_target,
  input  logic                 up_miss,
  input  logic [META_BITS-1:0] up_meta,
  input  logic [1:0]           debug_sel,
  output logic [31:0]          debug_data
);

  localparam int IDX_BITS = $clog2(ENTRIES);
  localparam int ENTRY_W  = 1 + TAG_BITS + 30 + CTR_BITS;
  localparam logic [CTR_MAX-1:0] CTR_INIT = ctr_init(CTR_BITS);

  state_e              state_q;
  logic [IDX_BITS-1:0] sweep_q;
  logic                valid_q;
  logic [31:0]         pc_q;
  logic                fwd_q;
  entry_t              fwd_ent_q;

  logic                ready, lu_accept, upd_en, up_hit, wr_en;
  logic [IDX_BITS-1:0] lu_idx, up_idx, pcq_idx, wr_addr, rd_addr;
  logic [TAG_BITS-1:0] up_tag, pcq_tag;
  logic [CTR_MAX-1:0]  ctr_new;
  logic [ENTRY_W-1:0]  wr_bits, rd_bits;
  entry_t              wr_ent, rd_ent, sel_ent;
  logic                hit;

  assign ready     = (state_q == ST_READY);
  assign lu_ready  = ready & ~stall;
  assign lu_accept = lu_valid & lu_ready;
  assign upd_en    = up_valid & ~stall & ready;

  assign lu_idx  = IDX_BITS'(pc_index(lu_pc, IDX_BITS));
  assign up_idx  = IDX_BITS'(pc_index(up_pc, IDX_BITS));
  assign pcq_idx = IDX_BITS'(pc_index(pc_q, IDX_BITS));
  assign up_tag  = TAG_BITS'(pc_tag(up_pc, IDX_BITS, TAG_BITS));
  assign pcq_tag = TAG_BITS'(pc_tag(pc_q, IDX_BITS, TAG_BITS));

  // The counter advances from the value carried in the meta, so no read-modify-write is needed.
  assign up_hit  = up_meta[META_BITS-1];
  assign ctr_new = ctr_next(CTR_MAX'(up_meta[CTR_BITS-1:0]), up_dir, CTR_BITS);

  // NOTE: every output of this block gets a default first so no latch is inferred.
  always_comb begin
    wr_en      = 1'b0;
    wr_addr    = sweep_q;
    wr_ent     = '0;
    wr_ent.ctr = CTR_INIT;
    if (state_q == ST_INIT) begin
      wr_en = 1'b1;
    end else if (upd_en && (up_dir || up_hit)) begin
      // Not-taken hits rewrite the target from execute, which equals the stored one.
      wr_en         = 1'b1;
      wr_addr       = up_idx;
      wr_ent.valid  = 1'b1;
      wr_ent.tag    = TAG_MAX'(up_tag);
      wr_ent.target = up_target[31:2];
      wr_ent.ctr    = ctr_new;
    end
  end

  assign wr_bits = {wr_ent.valid, wr_ent.tag[TAG_BITS-1:0], wr_ent.target,
                    wr_ent.ctr[CTR_BITS-1:0]};

  // While stalled the held PC is re-read so the registered RAM output stays put.
  assign rd_addr = lu_accept ? lu_idx : pcq_idx;

  bpred_ram #(
    .DEPTH (ENTRIES),
    .WIDTH (ENTRY_W)
  ) u_ram (
    .clk     (clk),
    .we_i    (wr_en),
    .waddr_i (wr_addr),
    .wdata_i (wr_bits),
    .raddr_i (rd_addr),
    .rdata_o (rd_bits)
  );

  always_comb begin
    rd_ent        = '0;
    rd_ent.valid  = rd_bits[ENTRY_W-1];
    rd_ent.tag    = TAG_MAX'(rd_bits[CTR_BITS+30 +: TAG_BITS]);
    rd_ent.target = rd_bits[CTR_BITS +: 30];
    rd_ent.ctr    = CTR_MAX'(rd_bits[CTR_BITS-1:0]);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_INIT;
      sweep_q   <= '0;
      valid_q   <= 1'b0;
      pc_q      <= '0;
      fwd_q     <= 1'b0;
      fwd_ent_q <= '0;
    end else begin
      if (state_q == ST_INIT) begin
        sweep_q <= sweep_q + IDX_BITS'(1);
        if (sweep_q == IDX_BITS'(ENTRIES - 1)) state_q <= ST_READY;
      end
      if (!stall) begin
        valid_q   <= lu_accept;
        if (lu_accept) pc_q <= lu_pc;
        fwd_q     <= lu_accept & wr_en & (wr_addr == lu_idx);
        fwd_ent_q <= wr_ent;
      end
    end
  end

  assign sel_ent = fwd_q ? fwd_ent_q : rd_ent;
  assign hit     = valid_q & sel_ent.valid & (sel_ent.tag[TAG_BITS-1:0] == pcq_tag);

  assign p_valid  = valid_q;
  assign p_hit    = hit;
  assign p_dir    = hit & sel_ent.ctr[CTR_BITS-1];
  assign p_target = !valid_q ? '0 : (hit ? {sel_ent.target, 2'b00} : pc_q + 32'd4);
  assign p_meta   = valid_q ? {hit, pcq_idx, sel_ent.ctr[CTR_BITS-1:0]} : '0;

`ifdef BPRED_DEBUG_CNT_EN
  logic [31:0] cnt_q [4];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 4; i++) cnt_q[i] <= '0;
    end else begin
      if (lu_accept)             cnt_q[0] <= cnt_q[0] + 32'd1;
      if (upd_en)                cnt_q[1] <= cnt_q[1] + 32'd1;
      if (upd_en && up_miss)     cnt_q[2] <= cnt_q[2] + 32'd1;
      if (upd_en && !up_miss)    cnt_q[3] <= cnt_q[3] + 32'd1;
    end
  end

  assign debug_data = cnt_q[debug_sel];
`else
  assign debug_data = '0;
`endif

  logic unused_ok;
  assign unused_ok = ^{wr_ent, sel_ent, up_target[1:0], up_meta, up_miss, debug_sel};

endmodule

// File: doc/bpred_btb_tagged.md
# bpred_btb_tagged

Parametrised, tagged successor to the baseline BTB/bimodal predictor that sits between fetch and execute. It looks up a fetch PC in a direct-mapped table holding valid, partial tag, target and an N-bit saturating counter. It returns a registered direction/target prediction one cycle later and applies resolved-branch updates from execute. It adds hardware table initialisation, tag-checked hits, same-cycle update-to-lookup forwarding and stall-hold of the prediction.

## Interface
Parameters:
- ENTRIES, 2048, table depth; power of two, ≥4; IDX_BITS = log2(ENTRIES)
- TAG_BITS, 8, partial tag width; ≥1; IDX_BITS+TAG_BITS ≤ 30
- CTR_BITS, 2, saturating counter width; 2..4
- META_BITS (derived), 1+IDX_BITS+CTR_BITS

Ports:
- clk  in  1  single clock, all logic on rising edge
- reset  in  1  synchronous, active-high
- stall  in  1  global pipeline stall
- lu_valid  in  1  lookup request
- lu_pc  in  32  fetch PC to predict
- lu_ready  out  1  lookup accepted this cycle when lu_valid & lu_ready
- p_valid  out  1  prediction valid
- p_hit  out  1  tag hit on a valid entry
- p_dir  out  1  predicted taken
- p_target  out  32  predicted target, bits [1:0] = 0
- p_meta  out  META_BITS  {hit, index, counter}; travels with the branch to execute
- up_valid  in  1  resolved-branch update
- up_pc  in  32  branch PC
- up_dir  in  1  actual direction
- up_target  in  32  actual target
- up_miss  in  1  branch was mispredicted (statistics only)
- up_meta  in  META_BITS  p_meta returned from execute
- debug_sel  in  2  debug counter select
- debug_data  out  32  selected debug counter

## Operation
- Index = pc[IDX_BITS+1:2]. Tag = pc[IDX_BITS+TAG_BITS+1:IDX_BITS+2]. Entry = {valid, tag, target[31:2], ctr}.
- FSM has two states, INIT and READY. Reset, including reset asserted mid-INIT, enters INIT with sweep index 0.
- INIT writes one entry per cycle with valid=0 and ctr=CTR_INIT, where CTR_INIT = 2^(CTR_BITS-1)-1 (weakly not-taken). After index ENTRIES-1 the FSM enters READY. The sweep lasts exactly ENTRIES cycles and is not paused by stall.
- lu_ready = READY & ~stall. Updates are ignored in INIT.
- Prediction:
  - p_hit = valid & (tag == lu tag)
  - p_dir = p_hit & ctr[CTR_BITS-1]
  - p_target = p_hit ? {target,2'b00} : lu_pc+4, computed on 32 bits with wrap
  - p_meta = {p_hit, index, ctr}
- Update is performed when up_valid & ~stall & READY.
  - New counter = saturating ±1 applied to up_meta ctr field; the table is not re-read. Taken increments and saturates at all-ones. Not-taken decrements and saturates at 0.
  - up_dir=1: write full entry with valid=1, tag from up_pc, target=up_target[31:2], new ctr. This allocates on a miss and replaces on a hit.
  - up_dir=0 with meta hit=1: write the entry with the same tag/target and the new ctr.
  - up_dir=0 with meta hit=0: no write.
- Forwarding: if an update writes index I in the same cycle a lookup of index I is accepted, the prediction uses the written entry, not the stale RAM data.

## Timing
- Lookup latency is 1 cycle. A lookup accepted at edge t yields p_valid=1 and the result after edge t+1.
- With no accepted lookup and no stall, p_valid=0 in the next cycle.
- When stall=1, all p_* outputs hold their values. The RAM read is re-issued against the held PC, so nothing is lost.
- An update takes effect for a lookup issued in the same cycle (via forwarding) or any later cycle.
- Reset values: p_valid=0, p_hit=0, p_dir=0, p_target=0, p_meta=0, lu_ready=0, debug_data=0. After reset, lu_ready rises after ENTRIES cycles.

## Configuration
- BPRED_DEBUG_CNT_EN defined: adds four 32-bit wrapping counters, all cleared by reset:
  - lookups, counting accepted lookups
  - updates, counting performed updates
  - misses, counting performed updates with up_miss=1
  - hits, counting performed updates with up_miss=0
- debug_sel 0/1/2/3 selects lookups/updates/misses/hits; debug_data is combinational from the counters.
- BPRED_DEBUG_CNT_EN undefined: no counters are built and debug_data is tied to 0.

## Structure
- Shared package bpred_pkg holds:
  - entry struct type
  - FSM state enum
  - ctr_next(ctr, dir) saturating function
  - CTR_INIT helper
  - index/tag extraction functions
- Sub-module bpred_ram: simple dual-port synchronous RAM, 1 read and 1 write port, width = entry width, read-old-data on collision. Top-level forwarding handles read/write collisions.

## Test plan
- ENTRIES=16, reset for 1 cycle -> lu_ready=0 for exactly 16 cycles then 1; first lookup of PC 0x40 -> p_hit=0, p_dir=0, p_target=0x44.
- Update PC 0x40, dir=1, target 0x100, meta {0,idx,01} -> next lookup of 0x40 gives p_hit=1, ctr=10, p_dir=1, p_target=0x100.
- Same-cycle update (0x80 taken → 0x200) and lookup of 0x80 -> prediction next cycle shows p_hit=1, p_target=0x200.
- Aliasing PCs 0x40 and 0x40+4*16 (same index, different tag) -> the second PC misses, and a taken update on it replaces the entry so 0x40 then misses.
- Counter saturation: four taken updates from ctr=11 -> ctr stays 11; four not-taken updates -> ctr reaches 00 and stays.
- Assert stall for 3 cycles after a lookup -> p_* hold and lu_ready=0; reset mid-INIT -> sweep restarts, lu_ready low for another full ENTRIES cycles; with BPRED_DEBUG_CNT_EN, 5 updates of which 2 have up_miss=1 -> debug_sel=2 reads 2 and debug_sel=3 reads 3.
